// File: rtl/gsram_master_if.sv
// gsram_master_if: request/response handshake between a synchronous master
// and the gsram_master controller.
//   req_valid/req_ready  single-beat request handshake
//   req_write            1 = write, 0 = read
//   req_addr/req_wdata   word address and write data
//   rsp_valid            one-cycle completion pulse (reads and writes)
//   rsp_rdata            last captured read data
//   rsp_err              access rejected by the optional range check
// modport master: request source; modport slave: the controller.
interface gsram_master_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/gsram_master.sv
// gsram_master: clocked initiator for the asynchronous generic SRAM bus.
// Each accepted request becomes SETUP (address/data settle, strobes low),
// ACCESS (one strobe high for ACCESS_CYCLES cycles) and HOLD (strobes low,
// address/data held, rsp_valid pulse). Read data is sampled on the edge that
// enters HOLD, i.e. while the read strobe is still high.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   req             gsram_master_if.slave request/response handshake
//   read, write     memory strobes
//   address         memory word address
//   data            bidirectional memory data bus (driven only for writes)
// Optional feature: define GSRAM_MASTER_ADDR_CHECK_EN to reject addresses
// outside [START_ADDR, START_ADDR+SIZE) with rsp_err and no bus activity.
module gsram_master #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 16,
    parameter int ACCESS_CYCLES = 3,
    parameter int START_ADDR    = 0,
    parameter int SIZE          = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    gsram_master_if.slave         req,
    output logic                  read,
    output logic                  write,
    output logic [ADDR_WIDTH-1:0] address,
    inout  wire  [DATA_WIDTH-1:0] data
);
    localparam int CW = $clog2(ACCESS_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t                state, state_nxt;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  write_q;
    logic                  err_q;
    logic                  in_range;
    logic                  last_beat;
    logic                  accept;
    logic                  drive_en;

`ifdef GSRAM_MASTER_ADDR_CHECK_EN
    // One extra bit so START_ADDR+SIZE may equal 2**ADDR_WIDTH.
    localparam logic [ADDR_WIDTH:0] RANGE_LO = (ADDR_WIDTH+1)'(START_ADDR);
    localparam logic [ADDR_WIDTH:0] RANGE_HI = (ADDR_WIDTH+1)'(START_ADDR + SIZE);
    assign in_range = ({1'b0, req.req_addr} >= RANGE_LO) &&
                      ({1'b0, req.req_addr} <  RANGE_HI);
`else
    assign in_range = 1'b1;
`endif

    assign last_beat = (cnt == '0);
    assign accept    = req.req_valid && (state == IDLE);

    always_comb begin
        state_nxt     = state;
        req.req_ready = 1'b0;
        req.rsp_valid = 1'b0;
        req.rsp_err   = 1'b0;
        read          = 1'b0;
        write         = 1'b0;
        drive_en      = 1'b0;
        case (state)
            IDLE: begin
                req.req_ready = 1'b1;
                // Rejected addresses skip the bus entirely and just respond.
                if (req.req_valid) state_nxt = in_range ? SETUP : HOLD;
            end
            SETUP: begin
                drive_en  = write_q;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                read     = !write_q;
                write    = write_q;
                drive_en = write_q;
                if (last_beat) state_nxt = HOLD;
            end
            HOLD: begin
                // err_q only ever gets set with the range check compiled in.
                drive_en      = write_q && !err_q;
                req.rsp_valid = 1'b1;
                req.rsp_err   = err_q;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign data          = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};
    assign req.rsp_rdata = rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            address <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                address <= req.req_addr;
                wdata_q <= req.req_wdata;
                write_q <= req.req_write;
                err_q   <= !in_range;
            end
            // Counter is loaded while in SETUP so it is valid on ACCESS entry.
            if (state == SETUP)
                cnt <= CW'(ACCESS_CYCLES - 1);
            else if (state == ACCESS && !last_beat)
                cnt <= cnt - 1'b1;
            // Sample on the edge entering HOLD, before the read strobe falls.
            if (state == ACCESS && last_beat && !write_q)
                rdata_q <= data;
        end
    end
endmodule

// File: tb/tb_gsram_master.sv
// tb_gsram_master: directed self-checking bench for gsram_master.
// DUT u0 uses the default ACCESS_CYCLES=3, DUT u1 uses ACCESS_CYCLES=5.
// Each DUT sees a 256-word behavioral memory; a bench probe driver on the
// data bus shows the DUT has released the bus (probe value reads back).
module tb_gsram_master;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    gsram_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) b0 ();
    gsram_master_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) b1 ();

    logic        rd0, wr0, rd1, wr1;
    logic [15:0] ad0, ad1;
    wire  [15:0] dt0, dt1;
    logic        probe_en;
    logic [15:0] probe_val;
    logic [15:0] mem0 [0:255];
    logic [15:0] mem1 [0:255];

    gsram_master #(.ACCESS_CYCLES(3)) u0 (
        .clk(clk), .rst(rst), .req(b0), .read(rd0), .write(wr0), .address(ad0), .data(dt0)
    );
    gsram_master #(.ACCESS_CYCLES(5)) u1 (
        .clk(clk), .rst(rst), .req(b1), .read(rd1), .write(wr1), .address(ad1), .data(dt1)
    );

    // Memory drives only for in-range reads; out-of-range reads float.
    assign dt0 = (rd0 && ad0 < 16'h0100) ? mem0[ad0[7:0]] : (probe_en ? probe_val : 16'hzzzz);
    assign dt1 = (rd1 && ad1 < 16'h0100) ? mem1[ad1[7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (wr0 && ad0 < 16'h0100) mem0[ad0[7:0]] <= dt0;
        if (wr1 && ad1 < 16'h0100) mem1[ad1[7:0]] <= dt1;
    end

    // One request on DUT sel; returns measurements for the caller to check.
    // lat counts edges from the accept edge (inclusive) to rsp_valid.
    task automatic txn(input bit sel, input bit wr, input logic [15:0] a, input logic [15:0] wd,
                       output int lat, output int rc, output int wc, output int dbad,
                       output logic [15:0] rdata, output logic err, output logic [15:0] hd,
                       output logic vld_next);
        int guard;
        @(negedge clk);
        if (sel) begin
            b1.req_valid = 1'b1; b1.req_write = wr; b1.req_addr = a; b1.req_wdata = wd;
        end else begin
            b0.req_valid = 1'b1; b0.req_write = wr; b0.req_addr = a; b0.req_wdata = wd;
        end
        guard = 0;
        while (!(sel ? b1.req_ready : b0.req_ready) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        b0.req_valid = 1'b0;
        b1.req_valid = 1'b0;
        lat = 1; rc = 0; wc = 0; dbad = 0;
        while (!(sel ? b1.rsp_valid : b0.rsp_valid) && lat < 40) begin
            if (sel ? rd1 : rd0) rc++;
            if (sel ? wr1 : wr0) begin
                wc++;
                if ((sel ? dt1 : dt0) !== wd) dbad++;
            end
            @(negedge clk);
            lat++;
        end
        rdata = sel ? b1.rsp_rdata : b0.rsp_rdata;
        err   = sel ? b1.rsp_err : b0.rsp_err;
        hd    = sel ? dt1 : dt0;
        @(negedge clk);
        vld_next = sel ? b1.rsp_valid : b0.rsp_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (rd0 !== 1'b0 || wr0 !== 1'b0) begin bad++; $display("FAIL reset_strobes got rd=%b wr=%b want 0 0", rd0, wr0); end
        total++; if (ad0 !== 16'h0000) begin bad++; $display("FAIL reset_address got %h want 0000", ad0); end
        total++; if (b0.req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got %b want 1", b0.req_ready); end
        total++; if (b0.rsp_valid !== 1'b0 || b0.rsp_err !== 1'b0) begin bad++; $display("FAIL reset_rsp got v=%b e=%b want 0 0", b0.rsp_valid, b0.rsp_err); end
        total++; if (b0.rsp_rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata got %h want 0000", b0.rsp_rdata); end
        probe_en = 1'b1; probe_val = 16'h5AA5;
        #1;
        total++; if (dt0 !== 16'h5AA5) begin bad++; $display("FAIL reset_data_released got %h want 5aa5", dt0); end
        probe_en = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        int lat, rc, wc, dbad; logic [15:0] rdata, hd; logic err, vn;
        txn(1'b0, 1'b1, 16'h0012, 16'hA5C3, lat, rc, wc, dbad, rdata, err, hd, vn);
        total++; if (wc !== 3 || rc !== 0) begin bad++; $display("FAIL wr_strobe_cycles got wr=%0d rd=%0d want 3 0", wc, rc); end
        total++; if (dbad !== 0) begin bad++; $display("FAIL wr_data_on_strobe got %0d bad cycles want 0", dbad); end
        total++; if (lat !== 5) begin bad++; $display("FAIL wr_latency got %0d want 5", lat); end
        total++; if (hd !== 16'hA5C3) begin bad++; $display("FAIL wr_hold_data got %h want a5c3", hd); end
        total++; if (rdata !== 16'h0000 || err !== 1'b0) begin bad++; $display("FAIL wr_rsp got rdata=%h err=%b want 0000 0", rdata, err); end
        total++; if (vn !== 1'b0) begin bad++; $display("FAIL wr_rsp_one_cycle got %b want 0", vn); end
        txn(1'b0, 1'b0, 16'h0012, 16'h0000, lat, rc, wc, dbad, rdata, err, hd, vn);
        total++; if (rc !== 3 || wc !== 0) begin bad++; $display("FAIL rd_strobe_cycles got rd=%0d wr=%0d want 3 0", rc, wc); end
        total++; if (rdata !== 16'hA5C3) begin bad++; $display("FAIL rd_data got %h want a5c3", rdata); end
        total++; if (lat !== 5 || vn !== 1'b0) begin bad++; $display("FAIL rd_timing got lat=%0d next=%b want 5 0", lat, vn); end
    endtask

    task automatic test_back_to_back();
        logic rdy [1:12];
        logic stb [1:12];
        int   nvld, first_hi, low1, low2, gap, k;
        int   lat, rc, wc, dbad; logic [15:0] rdata, hd; logic err, vn;
        @(negedge clk);
        b0.req_valid = 1'b1; b0.req_write = 1'b1; b0.req_addr = 16'h0001; b0.req_wdata = 16'h1111;
        nvld = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            rdy[n] = b0.req_ready;
            stb[n] = rd0 | wr0;
            if (b0.rsp_valid) nvld++;
            if (n == 1) begin b0.req_addr = 16'h0002; b0.req_wdata = 16'h2222; end
            if (n == 7) b0.req_valid = 1'b0;
        end
        first_hi = 13;
        for (int n = 12; n >= 1; n--) if (rdy[n]) first_hi = n;
        low1 = first_hi - 1;
        low2 = 0; k = first_hi + 1;
        while (k <= 12 && !rdy[k]) begin low2++; k++; end
        gap = 0; k = 1;
        while (k <= 12 && !stb[k]) k++;
        while (k <= 12 && stb[k]) k++;
        while (k <= 12 && !stb[k]) begin gap++; k++; end
        total++; if (low1 !== 5 || low2 !== 5) begin bad++; $display("FAIL b2b_ready_low got %0d,%0d want 5,5", low1, low2); end
        total++; if (gap < 3) begin bad++; $display("FAIL b2b_strobe_gap got %0d want >=3", gap); end
        total++; if (nvld !== 2) begin bad++; $display("FAIL b2b_rsp_count got %0d want 2", nvld); end
        txn(1'b0, 1'b0, 16'h0001, 16'h0000, lat, rc, wc, dbad, rdata, err, hd, vn);
        total++; if (rdata !== 16'h1111) begin bad++; $display("FAIL b2b_readback1 got %h want 1111", rdata); end
        txn(1'b0, 1'b0, 16'h0002, 16'h0000, lat, rc, wc, dbad, rdata, err, hd, vn);
        total++; if (rdata !== 16'h2222) begin bad++; $display("FAIL b2b_readback2 got %h want 2222", rdata); end
    endtask

    task automatic test_range();
        int lat, rc, wc, dbad; logic [15:0] rdata, hd; logic err, vn;
        txn(1'b0, 1'b0, 16'h0100, 16'h0000, lat, rc, wc, dbad, rdata, err, hd, vn);
`ifdef GSRAM_MASTER_ADDR_CHECK_EN
        // Rejected: straight to HOLD, so the response is in the cycle after accept.
        total++; if (rc !== 0 || wc !== 0) begin bad++; $display("FAIL range_no_strobe got rd=%0d wr=%0d want 0 0", rc, wc); end
        total++; if (lat !== 1 || err !== 1'b1) begin bad++; $display("FAIL range_err got lat=%0d err=%b want 1 1", lat, err); end
        total++; if (rdata !== 16'h2222) begin bad++; $display("FAIL range_rdata_kept got %h want 2222", rdata); end
`else
        total++; if (rc !== 3 || wc !== 0) begin bad++; $display("FAIL range_strobe got rd=%0d wr=%0d want 3 0", rc, wc); end
        total++; if (lat !== 5 || err !== 1'b0) begin bad++; $display("FAIL range_no_err got lat=%0d err=%b want 5 0", lat, err); end
`endif
    endtask

    task automatic test_reset_mid();
        int lat, rc, wc, dbad; logic [15:0] rdata, hd; logic err, vn;
        @(negedge clk);
        b0.req_valid = 1'b1; b0.req_write = 1'b0; b0.req_addr = 16'h0012;
        @(negedge clk);
        b0.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (rd0 !== 1'b1) begin bad++; $display("FAIL mid_read_active got %b want 1", rd0); end
        rst = 1'b1;
        probe_en = 1'b1; probe_val = 16'hC33C;
        #1;
        total++; if (rd0 !== 1'b0 || wr0 !== 1'b0 || b0.rsp_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_outputs got rd=%b wr=%b v=%b want 0 0 0", rd0, wr0, b0.rsp_valid); end
        total++; if (b0.req_ready !== 1'b1 || b0.rsp_rdata !== 16'h0000) begin bad++; $display("FAIL mid_reset_state got rdy=%b rdata=%h want 1 0000", b0.req_ready, b0.rsp_rdata); end
        total++; if (dt0 !== 16'hC33C) begin bad++; $display("FAIL mid_reset_data got %h want c33c", dt0); end
        @(negedge clk);
        probe_en = 1'b0;
        rst = 1'b0;
        txn(1'b0, 1'b0, 16'h0012, 16'h0000, lat, rc, wc, dbad, rdata, err, hd, vn);
        total++; if (rdata !== 16'hA5C3 || lat !== 5 || rc !== 3) begin bad++; $display("FAIL mid_recover got rdata=%h lat=%0d rd=%0d want a5c3 5 3", rdata, lat, rc); end
    endtask

    task automatic test_long_access();
        int lat, rc, wc, dbad; logic [15:0] rdata, hd; logic err, vn;
        txn(1'b1, 1'b1, 16'h00FF, 16'hFFFF, lat, rc, wc, dbad, rdata, err, hd, vn);
        total++; if (wc !== 5 || dbad !== 0) begin bad++; $display("FAIL long_wr_strobe got wr=%0d dbad=%0d want 5 0", wc, dbad); end
        total++; if (lat !== 7) begin bad++; $display("FAIL long_wr_latency got %0d want 7", lat); end
        txn(1'b1, 1'b0, 16'h00FF, 16'h0000, lat, rc, wc, dbad, rdata, err, hd, vn);
        total++; if (rc !== 5 || lat !== 7) begin bad++; $display("FAIL long_rd_timing got rd=%0d lat=%0d want 5 7", rc, lat); end
        total++; if (rdata !== 16'hFFFF) begin bad++; $display("FAIL long_rd_data got %h want ffff", rdata); end
    endtask

    initial begin
        probe_en = 1'b0; probe_val = 16'h0000;
        b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_addr = '0; b0.req_wdata = '0;
        b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0; b1.req_wdata = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_range();
        test_reset_mid();
        test_long_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout reached at %0t", $time);
        $fatal(1);
    end
endmodule
